// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer: branch condition codes,
// sequencer states and the default reset PC / branch offset width.
package fetch_pkg;

  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam int          IMM_W_DEF    = 9;

  typedef enum logic [2:0] {
    COND_NE = 3'b000,
    COND_EQ = 3'b001,
    COND_GT = 3'b010,
    COND_LT = 3'b011,
    COND_GE = 3'b100,
    COND_LE = 3'b101,
    COND_OV = 3'b110,
    COND_AL = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } fsm_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: condition code plus Z/N/V flags
// to a single taken bit.
module branch_cond_eval
  import fetch_pkg::*;
(
  input  logic [2:0] i_cond,
  input  logic       i_z,
  input  logic       i_n,
  input  logic       i_v,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (cond_e'(i_cond))
      COND_NE: o_taken = ~i_z;
      COND_EQ: o_taken = i_z;
      COND_GT: o_taken = ~i_z & ~i_n;
      COND_LT: o_taken = i_n;
      COND_GE: o_taken = i_z | ~i_n;
      COND_LE: o_taken = i_z | i_n;
      COND_OV: o_taken = i_v;
      default: o_taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter owner: req/ack instruction fetch, one-deep decode slot, branch redirect and halt.
// Define BRANCH_STATS_EN to add saturating br_total_cnt / br_taken_cnt outputs.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF,
  parameter int          IMM_W    = IMM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [15:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [15:0]      imem_data,
  output logic             inst_valid,
  output logic [15:0]      inst_out,
  output logic [15:0]      inst_pc,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             br_is_reg,
  input  logic [2:0]       br_cond,
  input  logic [IMM_W-1:0] br_imm,
  input  logic [15:0]      br_base,
  input  logic [15:0]      br_reg,
  input  logic             flag_z,
  input  logic             flag_n,
  input  logic             flag_v,
  input  logic             halt,
  output logic             flush,
  output logic             halted
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]      br_total_cnt,
  output logic [15:0]      br_taken_cnt
`endif
);

  fsm_e        r_state;
  fsm_e        w_state_next;
  logic [15:0] r_pc;
  logic [15:0] r_tgt;
  logic [15:0] r_slot_data;
  logic [15:0] r_slot_pc;
  logic        r_out;
  logic        r_drop;
  logic        r_slot_valid;

  logic        w_cond_true;
  logic        w_taken;
  logic        w_consume;
  logic        w_start;
  logic        w_ack;
  logic        w_pend_unacked;
  logic        w_keep;
  logic        w_slot_valid_next;
  logic [15:0] w_off;
  logic [15:0] w_target;

  branch_cond_eval u_cond (
    .i_cond  (br_cond),
    .i_z     (flag_z),
    .i_n     (flag_n),
    .i_v     (flag_v),
    .o_taken (w_cond_true)
  );

  assign w_off    = 16'($signed(br_imm)) << 1;
  assign w_target = br_is_reg ? br_reg : br_base + w_off;

  // rst gates the combinational starters so nothing is requested or flushed while reset is held.
  assign w_taken   = rst & br_valid & w_cond_true & (r_state != ST_HALTED);
  assign w_consume = r_slot_valid & ~stall;
  assign w_start   = rst & (r_state == ST_RUN) & ~r_out & (~r_slot_valid | w_consume)
                     & ~w_taken & ~halt;

  assign imem_req       = r_out | w_start;
  assign imem_addr      = r_pc;
  assign w_ack          = imem_req & imem_ack;
  assign w_pend_unacked = imem_req & ~imem_ack;
  assign w_keep         = w_ack & ~w_taken & ~r_drop & ~halt & (r_state == ST_RUN);

  assign w_slot_valid_next = w_taken ? 1'b0 :
                             w_keep  ? 1'b1 :
                             w_consume ? 1'b0 : r_slot_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:       if (halt && !w_taken) w_state_next = ST_HALT_PEND;
      ST_HALT_PEND: if (!w_pend_unacked && !w_slot_valid_next) w_state_next = ST_HALTED;
      default:      w_state_next = ST_HALTED;
    endcase
  end

  always_comb begin
    halted = (r_state == ST_HALTED);
  end

  // A redirect during an unacked fetch is parked in r_tgt so imem_addr stays put until the ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc         <= RESET_PC;
      r_tgt        <= '0;
      r_out        <= 1'b0;
      r_drop       <= 1'b0;
      r_slot_valid <= 1'b0;
      r_slot_data  <= '0;
      r_slot_pc    <= '0;
    end else begin
      r_out        <= w_pend_unacked;
      r_slot_valid <= w_slot_valid_next;
      if (w_keep) begin
        r_slot_data <= imem_data;
        r_slot_pc   <= r_pc;
      end
      if (w_taken && w_pend_unacked) begin
        r_tgt  <= w_target;
        r_drop <= 1'b1;
      end else if (w_taken) begin
        r_pc   <= w_target;
        r_drop <= 1'b0;
      end else if (w_ack && r_drop) begin
        r_pc   <= r_tgt;
        r_drop <= 1'b0;
      end else if (w_keep) begin
        r_pc <= r_pc + 16'd2;
      end
    end
  end

  assign inst_valid = r_slot_valid;
  assign inst_out   = r_slot_data;
  assign inst_pc    = r_slot_pc;
  assign flush      = w_taken;

`ifdef BRANCH_STATS_EN
  logic [15:0] r_br_total;
  logic [15:0] r_br_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_br_total <= '0;
      r_br_taken <= '0;
    end else begin
      if (br_valid && (r_state != ST_HALTED) && (r_br_total != 16'hFFFF))
        r_br_total <= r_br_total + 16'd1;
      if (w_taken && (r_br_taken != 16'hFFFF))
        r_br_taken <= r_br_taken + 16'd1;
    end
  end

  assign br_total_cnt = r_br_total;
  assign br_taken_cnt = r_br_taken;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer: program-order reference model plus directed scenarios.
// Build with BRANCH_STATS_EN defined to also check the branch counters.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic        inst_valid;
  logic [15:0] inst_out;
  logic [15:0] inst_pc;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_is_reg = 1'b0;
  logic [2:0]  br_cond = '0;
  logic [8:0]  br_imm = '0;
  logic [15:0] br_base = '0;
  logic [15:0] br_reg = '0;
  logic        flag_z = 1'b0;
  logic        flag_n = 1'b0;
  logic        flag_v = 1'b0;
  logic        halt = 1'b0;
  logic        flush;
  logic        halted;
`ifdef BRANCH_STATS_EN
  logic [15:0] br_total_cnt;
  logic [15:0] br_taken_cnt;
`endif

  logic [2:0]  ce_cond = '0;
  logic        ce_z = 1'b0;
  logic        ce_n = 1'b0;
  logic        ce_v = 1'b0;
  logic        ce_taken;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_is_reg  (br_is_reg),
    .br_cond    (br_cond),
    .br_imm     (br_imm),
    .br_base    (br_base),
    .br_reg     (br_reg),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_v     (flag_v),
    .halt       (halt),
    .flush      (flush),
    .halted     (halted)
`ifdef BRANCH_STATS_EN
    ,
    .br_total_cnt (br_total_cnt),
    .br_taken_cnt (br_taken_cnt)
`endif
  );

  branch_cond_eval u_ce (
    .i_cond  (ce_cond),
    .i_z     (ce_z),
    .i_n     (ce_n),
    .i_v     (ce_v),
    .o_taken (ce_taken)
  );

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  int unsigned n_cons = 0;
  int          lat_fix = 0;
  int          mem_wait = 0;
  bit          mem_busy = 1'b0;
  bit          m_halted = 1'b0;
  logic [15:0] m_exp_pc = 16'h0000;
  int unsigned m_tot = 0;
  int unsigned m_tak = 0;
  bit          prev_pend = 1'b0;
  logic [15:0] prev_addr = '0;
  bit          exp_taken;

  logic        s_req, s_ack, s_valid, s_flush, s_halted, s_new;
  logic [15:0] s_addr, s_out, s_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  function automatic bit cond_ref(input logic [2:0] c, input bit z, input bit n, input bit v);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] tgt_ref();
    int off;
    off = int'($signed(br_imm));
    if (br_is_reg) return br_reg;
    return 16'(int'(br_base) + off * 2);
  endfunction

  // One clock: answer the fetch, check against the program-order model, advance to posedge+1.
  task automatic cycle();
    #1;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_wait = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      end
      if (mem_wait == 0) begin
        imem_ack  = 1'b1;
        imem_data = mem_f(imem_addr);
        mem_busy  = 1'b0;
      end else begin
        imem_ack  = 1'b0;
        imem_data = 16'hDEAD;
        mem_wait--;
      end
    end else begin
      imem_ack = 1'b0;
      mem_busy = 1'b0;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_ack = imem_ack; s_valid = inst_valid;
    s_out = inst_out; s_pc = inst_pc; s_flush = flush; s_halted = halted;
    s_new = s_req & ~prev_pend;
    if (rst && prev_pend) begin
      check("req_hold", s_req, 1);
      check("addr_hold", s_addr, prev_addr);
    end
    exp_taken = rst && br_valid && !m_halted && cond_ref(br_cond, flag_z, flag_n, flag_v);
    if (rst) check("flush", s_flush, exp_taken);
    if (rst && s_valid && !stall && !exp_taken) begin
      $display("inst pc=%h data=%h", s_pc, s_out);
      check("inst_pc", s_pc, m_exp_pc);
      check("inst_data", s_out, mem_f(m_exp_pc));
      m_exp_pc = m_exp_pc + 16'd2;
      n_cons++;
    end
    if (exp_taken) m_exp_pc = tgt_ref();
    if (rst && br_valid && !m_halted && m_tot < 65535) m_tot++;
    if (exp_taken && m_tak < 65535) m_tak++;
    prev_pend = s_req & ~s_ack;
    prev_addr = s_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_new(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      cycle();
      if (s_new) ok = 1'b1;
    end
    check(tag, ok, 1);
  endtask

  task automatic set_br(input logic isreg, input logic [2:0] c, input logic [8:0] imm,
                        input logic [15:0] base, input logic [15:0] rg, input logic z);
    br_valid = 1'b1; br_is_reg = isreg; br_cond = c; br_imm = imm;
    br_base = base; br_reg = rg; flag_z = z; flag_n = 1'b0; flag_v = 1'b0;
  endtask

  initial begin
    logic [15:0] e;
    logic [15:0] a;
    bit          ok;
    int          cnt;

    // Condition evaluator, all codes against every flag combination.
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        ce_cond = 3'(c); ce_z = f[0]; ce_n = f[1]; ce_v = f[2];
        #1;
        check("cond_eval", ce_taken, cond_ref(3'(c), f[0], f[1], f[2]));
      end
    end
    @(posedge clk);
    #1;

    // Reset state.
    rst = 1'b0;
    cycle();
    check("rst_req", s_req, 0);
    check("rst_addr", s_addr, 16'h0000);
    check("rst_valid", s_valid, 0);
    check("rst_out", {s_out, s_pc}, 32'h0);
    check("rst_flush_halted", {s_flush, s_halted}, 2'b00);

    // Zero-latency streaming from RESET_PC.
    rst = 1'b1;
    lat_fix = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t1_req", s_req, 1);
      check("t1_addr", s_addr, 16'(2 * i));
      if (i > 0) check("t1_valid", s_valid, 1);
    end

    // Stall holds the slot and blocks fetch.
    e = m_exp_pc;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t2_req", s_req, 0);
      check("t2_hold", {s_valid, s_pc, s_out}, {1'b1, e, mem_f(e)});
    end
    stall = 1'b0;
    cycle();
    check("t2_next_addr", {s_req, s_addr}, {1'b1, 16'(e + 16'd2)});

    // PC-relative EQ branch, then the same branch not taken.
    set_br(1'b0, 3'b001, 9'h1FC, 16'h0010, 16'h0000, 1'b1);
    cycle();
    check("t3_flush", s_flush, 1);
    br_valid = 1'b0;
    cycle();
    check("t3_addr", {s_req, s_addr}, {1'b1, 16'h0008});
    cycle();
    set_br(1'b0, 3'b001, 9'h1FC, 16'h0010, 16'h0000, 1'b0);
    cycle();
    check("t3_no_flush", s_flush, 0);
    br_valid = 1'b0;

    // Register branch while a 3-cycle fetch is pending; target wraps afterwards.
    lat_fix = 3;
    wait_new("t4_wait_req");
    check("t4_req_addr", s_addr, m_exp_pc);
    a = s_addr;
    set_br(1'b1, 3'b111, 9'h000, 16'h0000, 16'hFFFE, 1'b0);
    cycle();
    check("t4_flush", s_flush, 1);
    check("t4_addr_held", s_addr, a);
    br_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 6 && !ok; i++) begin
      cycle();
      if (s_ack) ok = 1'b1;
    end
    check("t4_ack_seen", {ok, s_addr}, {1'b1, a});
    wait_new("t4_wait_tgt");
    check("t4_tgt_addr", s_addr, 16'hFFFE);
    wait_new("t4_wait_wrap");
    check("t4_wrap_addr", s_addr, 16'h0000);

    // Halt with a fetch outstanding.
    wait_new("t5_wait_req");
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    cnt = 0;
    e = 16'(n_cons);
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_new) cnt++;
    end
    check("t5_no_new_req", cnt, 0);
    check("t5_no_deliver", n_cons, e);
    check("t5_halted", {s_halted, s_req, s_valid}, 3'b100);
    m_halted = 1'b1;
    set_br(1'b1, 3'b111, 9'h000, 16'h0000, 16'h1234, 1'b0);
    cycle();
    check("t5_br_ignored", s_flush, 0);
    br_valid = 1'b0;
    cycle();
    check("t5_still_halted", {s_halted, s_req}, 2'b10);
    rst = 1'b0;
    cycle();
    check("t5_rst", {s_halted, s_req, s_addr}, {2'b00, 16'h0000});
    rst = 1'b1;
    m_halted = 1'b0;
    m_exp_pc = 16'h0000;
    cycle();
    check("t5_restart", {s_req, s_addr}, {1'b1, 16'h0000});

    // Randomized traffic: latency, stalls and branches.
    lat_fix = -1;
    cnt = int'(n_cons);
    for (int k = 0; k < 1500; k++) begin
      stall     = ($urandom_range(0, 3) == 0);
      br_valid  = ($urandom_range(0, 9) == 0);
      br_is_reg = 1'($urandom_range(0, 1));
      br_cond   = 3'($urandom_range(0, 7));
      br_imm    = 9'($urandom);
      br_base   = 16'($urandom);
      br_reg    = 16'($urandom);
      flag_z    = 1'($urandom_range(0, 1));
      flag_n    = 1'($urandom_range(0, 1));
      flag_v    = 1'($urandom_range(0, 1));
      cycle();
    end
    stall = 1'b0;
    br_valid = 1'b0;
    check("rand_progress", (int'(n_cons) - cnt) > 200, 1);

`ifdef BRANCH_STATS_EN
    check("stat_total", br_total_cnt, 16'(m_tot));
    check("stat_taken", br_taken_cnt, 16'(m_tak));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
